// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frame-synchronous game-state controller for the VGA pipeline.
// Click, hit and escape events are latched as pending flags during a frame and
// consumed at the next frame boundary (rising edge of vblnk_in), so every drawn
// frame sees one consistent state.
// Optional feature macro: GAME_STATE_PAUSE_EN adds the PAUSE state (11) and the
// esc-driven PLAY<->PAUSE transitions. Without it key_esc has no effect.
module game_state_ctrl #(
  parameter int BTN_X0      = 360,
  parameter int BTN_X1      = 660,
  parameter int BTN_Y0      = 334,
  parameter int BTN_Y1      = 434,
  parameter int OVER_FRAMES = 180
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        hit,
  input  logic        key_esc,
  output logic [1:0]  state,
  output logic        new_game,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    ST_MENU  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  localparam logic [11:0] X0       = 12'(BTN_X0);
  localparam logic [11:0] X1       = 12'(BTN_X1);
  localparam logic [11:0] Y0       = 12'(BTN_Y0);
  localparam logic [11:0] Y1       = 12'(BTN_Y1);
  localparam logic [9:0]  OVR_LAST = 10'(OVER_FRAMES - 1);
  localparam logic [9:0]  OVR_MAX  = 10'h3FF;

`ifdef GAME_STATE_PAUSE_EN
  localparam logic PAUSE_ON = 1'b1;
`else
  localparam logic PAUSE_ON = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        vblnk_dly_q, vblnk_dly_d;
  logic        mouse_left_q, mouse_left_d;
  logic        key_esc_q, key_esc_d;
  logic        p_start_q, p_start_d;
  logic        p_click_q, p_click_d;
  logic        p_esc_q, p_esc_d;
  logic        p_hit_q, p_hit_d;
  logic        new_game_q, new_game_d;
  logic        frame_tick_q, frame_tick_d;
  logic [9:0]  ovr_cnt_q, ovr_cnt_d;

  logic fb;
  logic click;
  logic esc_edge;
  logic in_btn;

  // Edge detection, button hit-test and pending-flag update (set beats clear at fb)
  always_comb begin
    vblnk_dly_d  = vblnk_in;
    mouse_left_d = mouse_left;
    key_esc_d    = key_esc;

    fb       = vblnk_in & ~vblnk_dly_q;
    click    = mouse_left & ~mouse_left_q;
    esc_edge = PAUSE_ON & key_esc & ~key_esc_q;
    in_btn   = (mouse_xpos >= X0) && (mouse_xpos <= X1) &&
               (mouse_ypos >= Y0) && (mouse_ypos <= Y1);

    p_start_d = (click & in_btn) | (p_start_q & ~fb);
    p_click_d = click            | (p_click_q & ~fb);
    p_esc_d   = esc_edge         | (p_esc_q   & ~fb);
    p_hit_d   = hit              | (p_hit_q   & ~fb);
  end

  // Next-state, OVER frame counter and output pulses, evaluated only at fb
  always_comb begin
    state_d      = state_q;
    ovr_cnt_d    = ovr_cnt_q;
    new_game_d   = 1'b0;
    frame_tick_d = fb;

    if (fb) begin
      case (state_q)
        ST_MENU: begin
          if (p_start_q) begin
            state_d    = ST_PLAY;
            new_game_d = 1'b1;
          end
        end
        ST_PLAY: begin
          if (p_hit_q) begin
            state_d   = ST_OVER;
            ovr_cnt_d = 10'd0;
          end else if (PAUSE_ON && p_esc_q) begin
            state_d = ST_PAUSE;
          end
        end
        ST_OVER: begin
          if (p_click_q || (ovr_cnt_q == OVR_LAST)) begin
            state_d = ST_MENU;
          end else if (ovr_cnt_q != OVR_MAX) begin
            ovr_cnt_d = ovr_cnt_q + 10'd1;
          end
        end
`ifdef GAME_STATE_PAUSE_EN
        ST_PAUSE: begin
          if (p_esc_q || p_click_q) begin
            state_d = ST_PLAY;
          end
        end
`else
        ST_PAUSE: begin
          state_d = ST_MENU;
        end
`endif
        default: begin
          state_d = ST_MENU;
        end
      endcase
    end
  end

  // State, edge, pending and pulse registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= ST_MENU;
      vblnk_dly_q  <= 1'b1;
      mouse_left_q <= 1'b0;
      key_esc_q    <= 1'b0;
      p_start_q    <= 1'b0;
      p_click_q    <= 1'b0;
      p_esc_q      <= 1'b0;
      p_hit_q      <= 1'b0;
      new_game_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      ovr_cnt_q    <= 10'd0;
    end else begin
      state_q      <= state_d;
      vblnk_dly_q  <= vblnk_dly_d;
      mouse_left_q <= mouse_left_d;
      key_esc_q    <= key_esc_d;
      p_start_q    <= p_start_d;
      p_click_q    <= p_click_d;
      p_esc_q      <= p_esc_d;
      p_hit_q      <= p_hit_d;
      new_game_q   <= new_game_d;
      frame_tick_q <= frame_tick_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  assign state      = state_q;
  assign new_game   = new_game_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: directed frames for game_state_ctrl. Each frame queues the
// {state,new_game} expected at its boundary; a monitor pops one entry per
// frame_tick. Build with GAME_STATE_PAUSE_EN defined to exercise PAUSE.
module tb_game_state_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk_in;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        hit;
  logic        key_esc;
  logic [1:0]  state;
  logic        new_game;
  logic        frame_tick;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  mon_exp;

  game_state_ctrl dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .mouse_left (mouse_left),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .hit        (hit),
    .key_esc    (key_esc),
    .state      (state),
    .new_game   (new_game),
    .frame_tick (frame_tick)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One frame: 6 low cycles with optional events, then 2 cycles of vblank
  task automatic applyStimulus(input logic do_click, input logic [11:0] x, input logic [11:0] y,
                               input logic do_hit, input logic do_esc, input logic click_on_fb,
                               input logic [1:0] exp_state, input logic exp_ng);
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      if (i == 1) begin
        if (do_click) begin
          mouse_xpos = x;
          mouse_ypos = y;
          mouse_left = 1'b1;
        end
        if (do_hit) hit = 1'b1;
        if (do_esc) key_esc = 1'b1;
      end
      if (i == 3) hit = 1'b0;
      if (i == 4) begin
        mouse_left = 1'b0;
        key_esc    = 1'b0;
      end
    end
    exp_q.push_back({exp_state, exp_ng});
    @(posedge pclk); #1;
    vblnk_in = 1'b1;
    if (click_on_fb) begin
      mouse_xpos = x;
      mouse_ypos = y;
      mouse_left = 1'b1;
    end
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    vblnk_in   = 1'b0;
    mouse_left = 1'b0;
  endtask

  task automatic idle_frames(input int n, input logic [1:0] exp_state);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, exp_state, 1'b0);
  endtask

  // Monitor: every frame_tick must match the next queued expectation
  always @(negedge pclk) begin
    if (!rst) begin
      if (frame_tick) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_tick", 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("tick_state_newgame", {29'd0, state, new_game}, {29'd0, mon_exp});
        end
      end else if (new_game) begin
        checkOutput("new_game_without_tick", 32'd1, 32'd0);
      end
    end
  end

  // Run-time bound
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; vblnk_in = 1'b1; mouse_left = 1'b0; mouse_xpos = 12'd0;
    mouse_ypos = 12'd0; hit = 1'b0; key_esc = 1'b0;
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;
    checkOutput("reset_state", {30'd0, state}, 32'd0);
    checkOutput("reset_new_game", {31'd0, new_game}, 32'd0);
    checkOutput("reset_frame_tick", {31'd0, frame_tick}, 32'd0);
    // vblank already high out of reset must not produce a boundary
    repeat (4) @(posedge pclk);
    #1 vblnk_in = 1'b0;

    idle_frames(3, 2'b00);

    // Button hit-test, including both inclusive corners
    applyStimulus(1'b1, 12'd200, 12'd400, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b1, 12'd359, 12'd334, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b1, 12'd660, 12'd435, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b1, 12'd660, 12'd434, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    idle_frames(1, 2'b01);

    // Esc while playing
`ifdef GAME_STATE_PAUSE_EN
    applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    idle_frames(1, 2'b11);
    applyStimulus(1'b1, 12'd10, 12'd10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
`else
    applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    idle_frames(1, 2'b01);
    applyStimulus(1'b1, 12'd10, 12'd10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
`endif

    // Hit and esc together: hit wins; then leave OVER by a click after fb 5
    applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    idle_frames(5, 2'b10);
    applyStimulus(1'b1, 12'd10, 12'd10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    // Click on the boundary cycle itself only counts at the following boundary
    applyStimulus(1'b0, 12'd500, 12'd400, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);

    // OVER timeout after exactly 180 boundaries
    applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    idle_frames(179, 2'b10);
    idle_frames(1, 2'b00);

    // Reset in OVER with ovr_cnt at 90 and a hit just before it
    applyStimulus(1'b1, 12'd360, 12'd334, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    applyStimulus(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
    idle_frames(90, 2'b10);
    @(posedge pclk); #1 hit = 1'b1;
    @(posedge pclk); #1 hit = 1'b0; rst = 1'b1;
    @(posedge pclk); #1 rst = 1'b0;
    checkOutput("rst_in_over_state", {30'd0, state}, 32'd0);
    checkOutput("rst_in_over_tick", {31'd0, frame_tick}, 32'd0);
    applyStimulus(1'b1, 12'd500, 12'd400, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
    idle_frames(2, 2'b01);

    repeat (5) @(posedge pclk);
    #1 checkOutput("pending_expectations", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
# game_state_ctrl

Frame-synchronous game-state controller for the VGA drawing pipeline. It turns mouse clicks, a collision/hit flag and an escape key into a 2-bit `state` code consumed by the drawing stages (background, menu frame, sprites). State changes happen only at the start of vertical blanking, so every drawn frame uses one consistent state. The block also emits a one-cycle `new_game` pulse that clears downstream game logic.

## Interface
Parameters:
- `BTN_X0`, default 360: start-button left edge, in hcount units.
- `BTN_X1`, default 660: start-button right edge, inclusive.
- `BTN_Y0`, default 334: start-button top edge, in vcount units.
- `BTN_Y1`, default 434: start-button bottom edge, inclusive.
- `OVER_FRAMES`, default 180: number of frames spent in OVER before returning automatically to MENU. Valid range 1..1023.

Ports:
- `pclk`  in  1  pixel clock; every input is synchronous to it.
- `rst`  in  1  reset, synchronous, active-high.
- `vblnk_in`  in  1  vertical blank from the timing chain.
- `mouse_left`  in  1  left button level.
- `mouse_xpos`  in  12  mouse x position.
- `mouse_ypos`  in  12  mouse y position.
- `hit`  in  1  collision flag from game logic; level or pulse.
- `key_esc`  in  1  escape key level.
- `state`  out  2  00 MENU, 01 PLAY, 10 OVER, 11 PAUSE.
- `new_game`  out  1  one-cycle pulse on the MENU→PLAY transition.
- `frame_tick`  out  1  one-cycle pulse per frame boundary.

## Operation
- Edge detection: `mouse_left` and `key_esc` are compared against their registered previous values. A rising edge is an event.
- Frame boundary (fb): `vblnk_in==1 && vblnk_d==0`. `vblnk_d` resets to 1.
- Pending flags, each 1 bit:
  - `p_start`: set on a click with BTN_X0≤x≤BTN_X1 and BTN_Y0≤y≤BTN_Y1 (both inclusive), using the coordinates from the edge cycle.
  - `p_click`: set on any click.
  - `p_esc`: set on an esc edge.
  - `p_hit`: set on any cycle where `hit==1`.
- All pending flags clear at every fb, whether or not the transition used them. If an event coincides with the fb cycle, setting takes priority over clearing, and the flag is held for the next fb.
- Transitions are evaluated only at an fb and use the pending flags:
  - MENU: `p_start` → PLAY, with `new_game` pulsed.
  - PLAY: `p_hit` → OVER. Otherwise `p_esc` → PAUSE (PAUSE_EN only). `p_hit` wins if both are set.
  - PAUSE: `p_esc` or `p_click` → PLAY. No `new_game` pulse.
  - OVER: `p_click` or `ovr_cnt==OVER_FRAMES-1` → MENU.
  - In every other case the state holds.
- `ovr_cnt` (10 bits):
  - Clears on entry to OVER.
  - Increments at each fb while in OVER.
  - Saturates at 1023.
- Illegal encoding 11 when PAUSE_EN is not defined → MENU at the next fb.

## Timing
- Reset values: `state`=00, `new_game`=0, `frame_tick`=0, all pending flags 0, `ovr_cnt`=0, edge registers 0, `vblnk_d`=1.
- Reset is honoured on any cycle. Asserting it mid-frame or mid-OVER forces MENU at the next clock edge, and all pending events are lost.
- Transition latency:
  - `state` changes on the same clock edge that samples the fb. It is visible in the cycle after the first `vblnk_in==1` sample.
  - `new_game` is high for exactly that one cycle.
  - `frame_tick` is high for one cycle per fb, aligned with the `state` update.
- Event-to-state latency runs from the event to the next fb. An event in the fb cycle itself takes effect one frame later.
- A `vblnk_in` held high continuously produces only one fb.
- After reset with `vblnk_in` already high, the first fb needs a 0→1 transition of `vblnk_in`.
- OVER timeout: exactly OVER_FRAMES fbs after entering OVER, with no click, `state` becomes 00.

## Configuration
- `GAME_STATE_PAUSE_EN`:
  - When defined: the PAUSE state (11) and the esc-driven transitions PLAY↔PAUSE exist.
  - When undefined: `key_esc` is ignored, `p_esc` is never set, `state` never outputs 11, and PLAY leaves only on `p_hit`. The port list is identical in both builds.

## Test plan
- Reset, then apply 3 fbs with no input → `state`=00 throughout, `frame_tick` 3 pulses, `new_game`=0.
- In MENU, click at (500,400) mid-frame → at the next fb `state`=01 and a 1-cycle `new_game`. A click at (200,400) instead → `state` stays 00.
- In PLAY, assert `hit` and a rising esc in the same frame with PAUSE_EN → `state`=10 (hit priority). After 180 fbs with no click → `state`=00. A click at fb 5 instead → 00 at fb 6.
- With PAUSE_EN: esc in PLAY → 11 at the next fb. A click → 01, with no `new_game`. Without PAUSE_EN: esc → `state` stays 01.
- A click exactly on the fb cycle in MENU → `state` stays 00 at that fb and becomes 01 at the following fb.
- Assert `rst` for 1 cycle while in OVER with `ovr_cnt`=90 → next cycle `state`=00. A pending `p_hit` from before the reset has no effect afterwards.
